// File: rtl/cache_fill_pkg.sv
// rtl/cache_fill_pkg.sv - shared types and size helpers for the cache fill controller
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CH_ICACHE = 0;
  localparam int CH_DCACHE = 1;

  function automatic int calc_bpw(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int calc_idx_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int calc_off_w(input int words, input int data_w);
    return $clog2(words * (data_w / 8));
  endfunction

endpackage

// File: rtl/cfc_line_addr.sv
// rtl/cfc_line_addr.sv - wrapped word index and byte address within a cache line
module cfc_line_addr #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 3,
  parameter int BPW    = 2
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [IDX_W-1:0]  start_idx_i,
  input  logic [IDX_W-1:0]  cnt_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic [ADDR_W-1:0] addr_o
);

  // IDX_W-bit addition wraps the index modulo the line length for free.
  assign idx_o  = start_idx_i + cnt_i;
  assign addr_o = base_i + ADDR_W'(idx_o) * ADDR_W'(BPW);

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - multi-channel cache line miss-fill controller
// Optional CACHE_FILL_CRIT_WORD_FIRST_EN: critical-word-first fill order and crit_valid output.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_LINE  = 8,
  parameter int NUM_REQ         = 2,
  localparam int CH_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int IDX_W = calc_idx_w(WORDS_PER_LINE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        miss_req,
  input  logic [NUM_REQ*ADDR_W-1:0] miss_addr,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      fill_we,
  output logic [CH_W-1:0]           fill_ch,
  output logic [IDX_W-1:0]          fill_idx,
  output logic [DATA_W-1:0]         fill_data,
  output logic                      tag_we,
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  output logic                      crit_valid,
`endif
  output logic [NUM_REQ-1:0]        fill_done,
  output logic                      busy,
  output logic                      protocol_err
);

  localparam int BPW   = calc_bpw(DATA_W);
  localparam int OFF_W = calc_off_w(WORDS_PER_LINE, DATA_W);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS_PER_LINE);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  start_q, start_d;
  logic [CNT_W-1:0]  iss_q, iss_d;
  logic [CNT_W-1:0]  rcv_q, rcv_d;
  logic              perr_q, perr_d;

  logic [CH_W-1:0]   grant_ch;
  logic [ADDR_W-1:0] grant_addr;
  logic [ADDR_W-1:0] iss_addr;
  logic [IDX_W-1:0]  rcv_idx;
  logic [IDX_W-1:0]  iss_idx_unused;
  logic [ADDR_W-1:0] rcv_addr_unused;
  logic              rcv_ok;

  cfc_line_addr #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .BPW(BPW)) u_iss_addr (
    .base_i      (base_q),
    .start_idx_i (start_q),
    .cnt_i       (iss_q[IDX_W-1:0]),
    .idx_o       (iss_idx_unused),
    .addr_o      (iss_addr)
  );

  cfc_line_addr #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .BPW(BPW)) u_rcv_addr (
    .base_i      (base_q),
    .start_idx_i (start_q),
    .cnt_i       (rcv_q[IDX_W-1:0]),
    .idx_o       (rcv_idx),
    .addr_o      (rcv_addr_unused)
  );

  // Highest-index requester wins; the last match in the loop is kept.
  always_comb begin
    grant_ch = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (miss_req[i]) grant_ch = CH_W'(i);
    end
    grant_addr = miss_addr[int'(grant_ch)*ADDR_W +: ADDR_W];
  end

  // Data is only accepted for a word that has actually been issued.
  assign rcv_ok = (state_q == FILL) && mem_valid && (rcv_q != iss_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      base_q  <= '0;
      start_q <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      base_q  <= base_d;
      start_q <= start_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    base_d  = base_q;
    start_d = start_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    perr_d  = perr_q | (mem_valid & ~rcv_ok);
    case (state_q)
      IDLE: begin
        if (|miss_req) begin
          state_d = FILL;
          ch_d    = grant_ch;
          base_d  = (grant_addr >> OFF_W) << OFF_W;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
          start_d = grant_addr[OFF_W-1 -: IDX_W];
`else
          start_d = '0;
`endif
          iss_d   = '0;
          rcv_d   = '0;
        end
      end
      FILL: begin
        if (iss_q != FULL) iss_d = iss_q + CNT_W'(1);
        if (rcv_ok) begin
          rcv_d = rcv_q + CNT_W'(1);
          if (rcv_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    fill_we   = 1'b0;
    fill_ch   = '0;
    fill_idx  = '0;
    fill_data = '0;
    tag_we    = 1'b0;
    fill_done = '0;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    crit_valid = 1'b0;
`endif
    busy         = (state_q != IDLE);
    protocol_err = perr_q;
    if (busy) fill_ch = ch_q;
    if (state_q == FILL && iss_q != FULL) begin
      mem_en   = 1'b1;
      mem_addr = iss_addr;
    end
    if (rcv_ok) begin
      fill_we   = 1'b1;
      fill_idx  = rcv_idx;
      fill_data = mem_rdata;
      tag_we    = (rcv_q == LAST);
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
      crit_valid = (rcv_q == '0);
`endif
    end
    if (state_q == DONE) fill_done = NUM_REQ'(1) << ch_q;
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - directed self-checking bench for cache_fill_ctrl
module tb_cache_fill_ctrl;
  import cache_fill_pkg::*;

  localparam int L  = 4;
  localparam int LW = 2;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [1:0]  miss_req  = '0;
  logic [31:0] miss_addr = '0;
  logic        mem_en, mem_valid;
  logic [15:0] mem_addr, mem_rdata;
  logic        fill_we, tag_we, busy, protocol_err;
  logic [0:0]  fill_ch;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;
  logic [1:0]  fill_done;
  logic        crit_valid;
  logic        inj = 1'b0;

  logic [3:0]  w_req  = '0;
  logic [63:0] w_addr = '0;
  logic        w_en, w_mvalid, w_we, w_tag, w_busy, w_perr;
  logic [15:0] w_maddr;
  logic [31:0] w_rdata, w_fdata;
  logic [1:0]  w_fch, w_fidx;
  logic [3:0]  w_done;
  logic        w_crit;

  cache_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_ch(fill_ch), .fill_idx(fill_idx), .fill_data(fill_data),
    .tag_we(tag_we),
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    .crit_valid(crit_valid),
`endif
    .fill_done(fill_done), .busy(busy), .protocol_err(protocol_err)
  );

  cache_fill_ctrl #(.DATA_W(32), .ADDR_W(16), .WORDS_PER_LINE(4), .NUM_REQ(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .miss_req(w_req), .miss_addr(w_addr),
    .mem_en(w_en), .mem_addr(w_maddr), .mem_valid(w_mvalid), .mem_rdata(w_rdata),
    .fill_we(w_we), .fill_ch(w_fch), .fill_idx(w_fidx), .fill_data(w_fdata),
    .tag_we(w_tag),
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    .crit_valid(w_crit),
`endif
    .fill_done(w_done), .busy(w_busy), .protocol_err(w_perr)
  );

`ifndef CACHE_FILL_CRIT_WORD_FIRST_EN
  assign crit_valid = 1'b0;
  assign w_crit     = 1'b0;
`endif

  // Fixed-latency pipelined memories; data is the address scrambled with a constant.
  logic [L-1:0]  pv = '0;
  logic [15:0]   pa [L];
  logic [LW-1:0] wpv = '0;
  logic [15:0]   wpa [LW];
  always @(posedge clk) begin
    if (!rst_n) pv <= '0;
    else        pv <= {pv[L-2:0], mem_en};
    pa[0] <= mem_addr;
    for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
    if (!rst_n) wpv <= '0;
    else        wpv <= {wpv[0], w_en};
    wpa[0] <= w_maddr;
    wpa[1] <= wpa[0];
  end
  assign mem_valid = pv[L-1] | inj;
  assign mem_rdata = pa[L-1] ^ 16'hC3A5;
  assign w_mvalid  = wpv[LW-1];
  assign w_rdata   = {16'h0000, wpa[LW-1]} ^ 32'hDEADBEEF;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  logic [15:0] exp_addr [8] = '{16'h1236, 16'h1238, 16'h123A, 16'h123C,
                                16'h123E, 16'h1230, 16'h1232, 16'h1234};
  logic [2:0]  exp_idx  [8] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
  logic [15:0] wexp     [4] = '{16'h0104, 16'h0108, 16'h010C, 16'h0100};
  logic [1:0]  wexp_idx0    = 2'd1;
`else
  logic [15:0] exp_addr [8] = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
                                16'h1238, 16'h123A, 16'h123C, 16'h123E};
  logic [2:0]  exp_idx  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [15:0] wexp     [4] = '{16'h0100, 16'h0104, 16'h0108, 16'h010C};
  logic [1:0]  wexp_idx0    = 2'd0;
`endif

  logic        o_en [40], o_we [40], o_tag [40], o_busy [40], o_crit [40];
  logic [15:0] o_addr [40], o_dat [40];
  logic [2:0]  o_idx [40];
  logic [0:0]  o_ch [40];
  logic [1:0]  o_done [40];

  task automatic observe(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      @(negedge clk);
      o_en[c] = mem_en;   o_addr[c] = mem_addr; o_we[c]  = fill_we;
      o_ch[c] = fill_ch;  o_idx[c]  = fill_idx; o_dat[c] = fill_data;
      o_tag[c] = tag_we;  o_done[c] = fill_done; o_busy[c] = busy;
      o_crit[c] = crit_valid;
      miss_req = miss_req & ~fill_done;
    end
  endtask

  task automatic start_miss(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1);
    @(negedge clk);
    miss_req  = req;
    miss_addr = {a1, a0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_en, mem_addr, fill_we, fill_ch, fill_idx, fill_data, tag_we} !== '0) begin
      errors++;
      $display("FAIL reset_fill_outputs got en=%b addr=%h we=%b ch=%b idx=%0d data=%h tag=%b, all 0 required",
               mem_en, mem_addr, fill_we, fill_ch, fill_idx, fill_data, tag_we);
    end
    checks++;
    if ({fill_done, busy, protocol_err, crit_valid} !== '0) begin
      errors++;
      $display("FAIL reset_status got done=%b busy=%b perr=%b crit=%b, all 0 required",
               fill_done, busy, protocol_err, crit_valid);
    end
    checks++;
    if ({w_en, w_maddr, w_we, w_fdata, w_tag, w_done, w_busy, w_perr} !== '0) begin
      errors++;
      $display("FAIL reset_wide got en=%b addr=%h we=%b done=%b busy=%b perr=%b, all 0 required",
               w_en, w_maddr, w_we, w_done, w_busy, w_perr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start_miss(2'b01, 16'h1236, 16'h0000);
    observe(1, 14);
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (c <= 8) begin
        if ({o_en[c], o_addr[c]} !== {1'b1, exp_addr[c-1]}) begin
          errors++;
          $display("FAIL basic_issue cycle %0d got en=%b addr=%h, en=1 addr=%h required",
                   c, o_en[c], o_addr[c], exp_addr[c-1]);
        end
      end else if (o_en[c] !== 1'b0) begin
        errors++;
        $display("FAIL basic_issue_end cycle %0d got en=%b, en=0 required", c, o_en[c]);
      end
    end
    for (int c = 4; c <= 13; c++) begin
      checks++;
      if (c >= 5 && c <= 12) begin
        if ({o_we[c], o_idx[c], o_dat[c], o_tag[c], o_ch[c]} !==
            {1'b1, exp_idx[c-5], exp_addr[c-5] ^ 16'hC3A5, (c == 12), 1'(CH_ICACHE)}) begin
          errors++;
          $display("FAIL basic_fill cycle %0d got we=%b idx=%0d data=%h tag=%b ch=%0d, idx=%0d data=%h required",
                   c, o_we[c], o_idx[c], o_dat[c], o_tag[c], o_ch[c], exp_idx[c-5], exp_addr[c-5] ^ 16'hC3A5);
        end
      end else if ({o_we[c], o_tag[c]} !== 2'b00) begin
        errors++;
        $display("FAIL basic_fill_idle cycle %0d got we=%b tag=%b, both 0 required", c, o_we[c], o_tag[c]);
      end
    end
    checks++;
    if ({o_done[12], o_done[13], o_done[14]} !== {2'b00, 2'b01, 2'b00}) begin
      errors++;
      $display("FAIL basic_done got c12=%b c13=%b c14=%b, 00/01/00 required", o_done[12], o_done[13], o_done[14]);
    end
    checks++;
    if ({o_busy[1], o_busy[13], o_busy[14]} !== 3'b110) begin
      errors++;
      $display("FAIL basic_busy got c1=%b c13=%b c14=%b, 1/1/0 required", o_busy[1], o_busy[13], o_busy[14]);
    end
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    checks++;
    if ({o_crit[4], o_crit[5], o_crit[6]} !== 3'b010) begin
      errors++;
      $display("FAIL basic_crit got c4=%b c5=%b c6=%b, 0/1/0 required", o_crit[4], o_crit[5], o_crit[6]);
    end
`endif
  endtask

  task automatic test_arb();
    start_miss(2'b11, 16'h0040, 16'h8010);
    observe(1, 28);
    checks++;
    if ({o_en[1], o_addr[1], o_en[8], o_addr[8]} !== {1'b1, 16'h8010, 1'b1, 16'h801E}) begin
      errors++;
      $display("FAIL arb_ch1_issue got c1=%b/%h c8=%b/%h, 1/8010 1/801E required",
               o_en[1], o_addr[1], o_en[8], o_addr[8]);
    end
    checks++;
    if ({o_we[5], o_ch[5], o_dat[5]} !== {1'b1, 1'(CH_DCACHE), 16'h8010 ^ 16'hC3A5}) begin
      errors++;
      $display("FAIL arb_ch1_fill got we=%b ch=%0d data=%h, 1/1/%h required",
               o_we[5], o_ch[5], o_dat[5], 16'h8010 ^ 16'hC3A5);
    end
    checks++;
    if ({o_done[13], o_busy[14]} !== {2'b10, 1'b0}) begin
      errors++;
      $display("FAIL arb_ch1_done got done=%b busy14=%b, done=10 busy14=0 required", o_done[13], o_busy[14]);
    end
    checks++;
    if ({o_en[14], o_en[15], o_addr[15]} !== {1'b0, 1'b1, 16'h0040}) begin
      errors++;
      $display("FAIL arb_ch0_issue got c14=%b c15=%b/%h, 0 then 1/0040 required", o_en[14], o_en[15], o_addr[15]);
    end
    checks++;
    if ({o_we[19], o_ch[19], o_dat[19]} !== {1'b1, 1'(CH_ICACHE), 16'h0040 ^ 16'hC3A5}) begin
      errors++;
      $display("FAIL arb_ch0_fill got we=%b ch=%0d data=%h, 1/0/%h required",
               o_we[19], o_ch[19], o_dat[19], 16'h0040 ^ 16'hC3A5);
    end
    checks++;
    if ({o_done[26], o_done[27], o_tag[26]} !== {2'b00, 2'b01, 1'b1}) begin
      errors++;
      $display("FAIL arb_ch0_done got c26=%b c27=%b tag26=%b, 00/01/1 required", o_done[26], o_done[27], o_tag[26]);
    end
  endtask

  task automatic test_reset_mid();
    logic tag_seen;
    start_miss(2'b01, 16'h1236, 16'h0000);
    observe(1, 7);
    rst_n = 1'b0;
    observe(8, 8);
    rst_n = 1'b1;
    checks++;
    if ({o_en[8], o_addr[8], o_we[8], o_tag[8], o_done[8], o_busy[8]} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got en=%b addr=%h we=%b tag=%b done=%b busy=%b, all 0 required",
               o_en[8], o_addr[8], o_we[8], o_tag[8], o_done[8], o_busy[8]);
    end
    observe(9, 22);
    tag_seen = 1'b0;
    for (int c = 1; c <= 8; c++) tag_seen |= o_tag[c];
    checks++;
    if (tag_seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_tag got tag_we=%b during aborted fill, 0 required", tag_seen);
    end
    checks++;
    if ({o_en[9], o_addr[9], o_we[13], o_idx[13]} !== {1'b1, exp_addr[0], 1'b1, exp_idx[0]}) begin
      errors++;
      $display("FAIL rstmid_restart got en=%b addr=%h we=%b idx=%0d, 1/%h/1/%0d required",
               o_en[9], o_addr[9], o_we[13], o_idx[13], exp_addr[0], exp_idx[0]);
    end
    checks++;
    if ({o_tag[20], o_done[21], protocol_err} !== {1'b1, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_complete got tag20=%b done21=%b perr=%b, 1/01/0 required",
               o_tag[20], o_done[21], protocol_err);
    end
  endtask

  task automatic test_protocol();
    @(negedge clk);
    inj = 1'b1;
    #1;
    checks++;
    if ({fill_we, protocol_err, busy} !== 3'b000) begin
      errors++;
      $display("FAIL perr_drop got we=%b perr=%b busy=%b, all 0 required", fill_we, protocol_err, busy);
    end
    @(negedge clk);
    inj = 1'b0;
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL perr_set got %b, 1 required", protocol_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({protocol_err, fill_we} !== 2'b10) begin
      errors++;
      $display("FAIL perr_sticky got perr=%b we=%b, 1/0 required", protocol_err, fill_we);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_clear got %b, 0 required", protocol_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wide();
    @(negedge clk);
    w_req  = 4'b0110;
    w_addr = {16'h0000, 16'h0104, 16'h0230, 16'h0000};
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        checks++;
        if ({w_en, w_maddr} !== {1'b1, wexp[c-1]}) begin
          errors++;
          $display("FAIL wide_issue cycle %0d got en=%b addr=%h, 1/%h required", c, w_en, w_maddr, wexp[c-1]);
        end
      end
      if (c == 3) begin
        checks++;
        if ({w_we, w_fch, w_fidx, w_fdata} !== {1'b1, 2'd2, wexp_idx0, {16'h0000, wexp[0]} ^ 32'hDEADBEEF}) begin
          errors++;
          $display("FAIL wide_fill got we=%b ch=%0d idx=%0d data=%h, ch=2 idx=%0d data=%h required",
                   w_we, w_fch, w_fidx, w_fdata, wexp_idx0, {16'h0000, wexp[0]} ^ 32'hDEADBEEF);
        end
      end
      if (c == 6) begin
        checks++;
        if ({w_tag, w_done} !== {1'b1, 4'b0000}) begin
          errors++;
          $display("FAIL wide_tag got tag=%b done=%b, 1/0000 required", w_tag, w_done);
        end
      end
      if (c == 7) begin
        checks++;
        if (w_done !== 4'b0100) begin
          errors++;
          $display("FAIL wide_done_ch2 got %b, 0100 required", w_done);
        end
      end
      if (c == 9) begin
        checks++;
        if ({w_en, w_maddr, w_fch} !== {1'b1, 16'h0230, 2'd1}) begin
          errors++;
          $display("FAIL wide_ch1_issue got en=%b addr=%h ch=%0d, 1/0230/1 required", w_en, w_maddr, w_fch);
        end
      end
      if (c == 15) begin
        checks++;
        if ({w_done, w_perr} !== {4'b0010, 1'b0}) begin
          errors++;
          $display("FAIL wide_done_ch1 got done=%b perr=%b, 0010/0 required", w_done, w_perr);
        end
      end
      w_req = w_req & ~w_done;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arb();
    test_reset_mid();
    test_protocol();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
